sm_uart_loader: RTL and testbench

//  Debug write path into the core: receives 8N1 UART bytes on a board pin, packs

---
 rtl/sm_uart_loader.sv | 154 +++++++++++++++
 tb/tb_sm_uart_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_uart_loader.sv
// sm_uart_loader: 8N1 UART receiver that packs bytes into 32-bit words
// and emits one write strobe per word at an auto-incrementing address.
module sm_uart_loader #(
  parameter int BAUD_DIV     = 434,
  parameter int ADDR_WIDTH   = 6,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  wEnable,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic [31:0]           wData,
  output logic                  busy,
  output logic                  frameErr
);

  localparam int CW     = $clog2(BAUD_DIV);
  localparam int TO_CYC = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW     = $clog2(TO_CYC + 1);

  localparam logic [CW-1:0] HALF    = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);
  localparam logic [TW-1:0] TO_SAT  = TW'(TO_CYC);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_n;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [1:0]      byte_cnt;
  logic [23:0]     pack;
  logic [TW-1:0]   idle_cnt;
  logic            start_det;
  logic            bit_smp;
  logic            byte_ok;
  logic            byte_bad;
  logic            timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_det = 1'b0;
    bit_smp   = 1'b0;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n   = START;
          start_det = 1'b1;
        end else if (idle_cnt == TO_LAST) begin
          timeout = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF) state_n = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt == LAST) begin
          bit_smp = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          state_n  = IDLE;
          byte_ok  = rx_s;
          byte_bad = !rx_s;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_cnt <= '0;
      pack     <= '0;
      idle_cnt <= '0;
      wEnable  <= 1'b0;
      wAddr    <= '0;
      wData    <= '0;
      frameErr <= 1'b0;
    end else begin
      wEnable  <= 1'b0;
      frameErr <= byte_bad;

      if (state_n != state || bit_smp) cnt <= '0;
      else                             cnt <= cnt + CW'(1);

      if (start_det) bit_idx <= '0;
      if (bit_smp) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (wEnable) wAddr <= wAddr + ADDR_WIDTH'(1);

      if (byte_ok) begin
        unique case (byte_cnt)
          2'd0: pack[7:0]   <= shreg;
          2'd1: pack[15:8]  <= shreg;
          2'd2: pack[23:16] <= shreg;
          2'd3: begin
            wData   <= {shreg, pack};
            wEnable <= 1'b1;
          end
        endcase
        byte_cnt <= byte_cnt + 2'd1;
      end

      // idle time only accumulates between frames and saturates once fired
      if (start_det)
        idle_cnt <= '0;
      else if (state == IDLE && idle_cnt != TO_SAT)
        idle_cnt <= idle_cnt + TW'(1);

      if (timeout) begin
        byte_cnt <= '0;
        wAddr    <= '0;
      end
    end
  end

  assign busy = (state != IDLE) || (byte_cnt != 2'd0);

endmodule

// File: tb/tb_sm_uart_loader.sv
// tb_sm_uart_loader: directed UART frames checked against a word-level
// packing model (byte list -> expected strobes) plus literal pins.
module tb_sm_uart_loader;

  localparam int BD  = 8;
  localparam int AW  = 4;
  localparam int TOB = 16;
  localparam int GAP = 16;
  localparam int LAT = 79;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          wEnable;
  logic [AW-1:0] wAddr;
  logic [31:0]   wData;
  logic          busy;
  logic          frameErr;

  sm_uart_loader #(
    .BAUD_DIV(BD),
    .ADDR_WIDTH(AW),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .wEnable(wEnable),
    .wAddr(wAddr),
    .wData(wData),
    .busy(busy),
    .frameErr(frameErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            t;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pend[$];
  int         m_addr = 0;

  task automatic model_byte(input logic [7:0] b, input bit ok, input int t);
    exp_t e;
    if (ok) begin
      pend.push_back(b);
      if (pend.size() == 4) begin
        e.data = {pend[3], pend[2], pend[1], pend[0]};
        e.addr = AW'(m_addr);
        e.t    = t;
        exp_q.push_back(e);
        m_addr = (m_addr + 1) % (1 << AW);
        pend.delete();
      end
    end
  endtask

  task automatic model_clear();
    pend.delete();
    m_addr = 0;
  endtask

  int         n_we = 0;
  int         n_fe = 0;
  logic [31:0] last_data = '0;
  bit         prev_we = 0;
  bit         prev_fe = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_data = '0;
      prev_we   = 0;
      prev_fe   = 0;
    end else begin
      if (wEnable) begin
        n_we++;
        check("strobe_width", 32'(prev_we), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_addr", 32'(wAddr), 32'(e.addr));
          check("strobe_data", wData, e.data);
          check("strobe_latency", 32'(cyc - e.t), 32'(LAT));
          last_data = e.data;
        end
      end else begin
        check("data_hold", wData, last_data);
      end
      if (frameErr) begin
        n_fe++;
        check("ferr_width", 32'(prev_fe), 32'd0);
      end
      prev_we = wEnable;
      prev_fe = frameErr;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(negedge clk);
    rx = 1'b0;
    model_byte(b, stop, cyc);
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      send_byte(tmp[7:0], 1'b1);
    end
  endtask

  int  fe0;
  int  we0;
  bit  saw_busy;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wEnable", 32'(wEnable), 32'd0);
    check("rst_wAddr", 32'(wAddr), 32'd0);
    check("rst_wData", wData, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frameErr", 32'(frameErr), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single word
    send_word(32'h12345678);
    check("t1_data", wData, 32'h12345678);
    check("t1_addr_next", 32'(wAddr), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // two words from bytes 01..08
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    check("t2_data", wData, 32'h08070605);
    check("t2_addr_next", 32'(wAddr), 32'd3);

    // bad stop bit between bytes 2 and 3
    fe0 = n_fe;
    we0 = n_we;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h99, 1'b0);
    check("t3_ferr_once", 32'(n_fe - fe0), 32'd1);
    check("t3_no_strobe_yet", 32'(n_we - we0), 32'd0);
    check("t3_busy_partial", 32'(busy), 32'd1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("t3_data", wData, 32'h44332211);
    check("t3_strobes", 32'(n_we - we0), 32'd1);

    // 2-cycle low glitch
    fe0 = n_fe;
    we0 = n_we;
    saw_busy = 0;
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    check("t4_start_seen", 32'(saw_busy), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_no_ferr", 32'(n_fe - fe0), 32'd0);
    check("t4_no_strobe", 32'(n_we - we0), 32'd0);

    // partial word then idle timeout
    we0 = n_we;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check("t5_busy_partial", 32'(busy), 32'd1);
    model_clear();
    repeat (20 * BD) @(negedge clk);
    check("t5_busy_timeout", 32'(busy), 32'd0);
    check("t5_addr_timeout", 32'(wAddr), 32'd0);
    check("t5_no_strobe", 32'(n_we - we0), 32'd0);
    send_word(32'hC4C3C2C1);
    check("t5_data", wData, 32'hC4C3C2C1);
    check("t5_addr_next", 32'(wAddr), 32'd1);

    // 17 words wrap the address
    we0 = n_we;
    for (int w = 0; w < 17; w++) send_word(32'hA5000000 + 32'(w * 7));
    check("t6_strobes", 32'(n_we - we0), 32'd17);
    check("t6_addr_wrap", 32'(wAddr), 32'd2);

    // rx held low, then reset mid-frame
    send_byte(8'hE1, 1'b1);
    send_byte(8'hE2, 1'b1);
    fe0 = n_fe;
    we0 = n_we;
    @(negedge clk);
    rx = 1'b0;
    repeat (280) @(negedge clk);
    check("t6_low_ferrs", 32'(n_fe - fe0), 32'd3);
    check("t6_low_no_strobe", 32'(n_we - we0), 32'd0);
    check("t6_low_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    check("t6_rst_wEnable", 32'(wEnable), 32'd0);
    check("t6_rst_wAddr", 32'(wAddr), 32'd0);
    check("t6_rst_wData", wData, 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_frameErr", 32'(frameErr), 32'd0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_post_busy", 32'(busy), 32'd0);
    check("t6_post_no_strobe", 32'(n_we - we0), 32'd0);
    send_word(32'hF3F2F1F0);
    check("t6_post_data", wData, 32'hF3F2F1F0);
    check("t6_post_addr_next", 32'(wAddr), 32'd1);
    check("pending_strobes", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
